conv_line_ctrl: RTL and testbench

- Sequencer for the KxK PE array and its per-row line/psum FIFOs in the CNN accelerator TOP.
- Replaces hand-driven set_wgt/set_ifm/set_reg/wr_en/rd_en/rd_clr/wr_clr sequencing with a parameterised schedule for one IFM_W x IFM_H feature map.
- Handles pixel intake handshake, row gaps, psum FIFO read/write timing, output-FIFO drain, and completion signalling.

---
 rtl/conv_line_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_conv_line_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_line_ctrl.sv
// Schedules one IFM_W x IFM_H feature map through the KxK PE array and its per-row psum FIFOs.
// Pixel intake is valid/ready; FIFO strobes replay each window slot through a PIPE_DLY-deep flag line.
module conv_line_ctrl #(
    parameter int KERNEL_SIZE = 3,
    parameter int IFM_W       = 9,
    parameter int IFM_H       = 9,
    parameter int PIPE_DLY    = 3,
    parameter int GAP_CYC     = 2,
    parameter int FIFO_SIZE   = 10,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk2,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   ifm_valid,
    output logic                   ifm_ready,
    input  logic                   ofm_ready,
    output logic                   set_wgt,
    output logic                   set_ifm,
    output logic                   set_reg,
    output logic [KERNEL_SIZE-1:0] wr_en,
    output logic [KERNEL_SIZE-1:0] rd_en,
    output logic                   rd_clr,
    output logic                   wr_clr,
    output logic                   ofm_valid,
    output logic                   busy,
    output logic                   done
);

    localparam logic [CNT_WIDTH-1:0] COL_LAST   = CNT_WIDTH'(IFM_W - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST   = CNT_WIDTH'(IFM_H - 1);
    localparam logic [CNT_WIDTH-1:0] SLOT_COL   = CNT_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST   = CNT_WIDTH'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] OUT_MAX    = CNT_WIDTH'(FIFO_SIZE);
    localparam int                   OROW_LAST  = IFM_H - KERNEL_SIZE;

    if (IFM_W - KERNEL_SIZE + 1 > FIFO_SIZE) begin : g_chk_fifo
        $error("conv_line_ctrl: one output row does not fit in the psum FIFO");
    end
    if (PIPE_DLY < 2) begin : g_chk_dly
        $error("conv_line_ctrl: PIPE_DLY must be at least 2");
    end
    if (KERNEL_SIZE < 2) begin : g_chk_k
        $error("conv_line_ctrl: KERNEL_SIZE must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_WGT,
        S_ROW,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                                   state;
    state_t                                   state_nxt;
    logic [CNT_WIDTH-1:0]                     row;
    logic [CNT_WIDTH-1:0]                     col;
    logic [CNT_WIDTH-1:0]                     gap_cnt;
    logic [CNT_WIDTH-1:0]                     out_cnt;
    logic [PIPE_DLY-1:0][KERNEL_SIZE-1:0]     dly_line;
    logic [KERNEL_SIZE-1:0]                   slot_flags;
    logic                                     xfer;
    logic                                     row_end;
    logic                                     dly_empty;
    logic                                     out_wr;

    assign xfer      = ifm_ready & ifm_valid;
    assign row_end   = xfer && (col == COL_LAST);
    assign dly_empty = (dly_line == '0);

    always_comb begin
        state_nxt = state;
        ifm_ready = 1'b0;
        set_wgt   = 1'b0;
        rd_clr    = 1'b0;
        wr_clr    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                busy      = 1'b1;
                rd_clr    = 1'b1;
                wr_clr    = 1'b1;
                state_nxt = S_LOAD_WGT;
            end
            S_LOAD_WGT: begin
                busy      = 1'b1;
                set_wgt   = 1'b1;
                state_nxt = S_ROW;
            end
            S_ROW: begin
                busy      = 1'b1;
                ifm_ready = 1'b1;
                if (row_end) begin
                    if (row == ROW_LAST) state_nxt = S_DRAIN;
                    else if (GAP_CYC > 0) state_nxt = S_GAP;
                    else state_nxt = S_ROW;
                end
            end
            S_GAP: begin
                busy = 1'b1;
                if (gap_cnt == GAP_LAST) state_nxt = S_ROW;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (dly_empty && (out_cnt == '0)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Row and column track the pixel about to be accepted; row is left at the last row after the map.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            row     <= '0;
            col     <= '0;
            gap_cnt <= '0;
        end else begin
            if (state == S_LOAD_WGT) begin
                row <= '0;
                col <= '0;
            end else if (xfer) begin
                if (row_end) begin
                    col <= '0;
                    if (row != ROW_LAST) row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
            else                gap_cnt <= '0;
        end
    end

    // A slot feeds PE row k only when output row (row - k) lies inside the valid output range.
    always_comb begin
        slot_flags = '0;
        if (xfer && (col >= SLOT_COL)) begin
            for (int k = 0; k < KERNEL_SIZE; k++) begin
                if ((int'(row) >= k) && (int'(row) <= OROW_LAST + k)) slot_flags[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) dly_line <= '0;
        else        dly_line <= {dly_line[PIPE_DLY-2:0], slot_flags};
    end

    // Reads of FIFO k-1 lead the write into FIFO k by one cycle so the psum is ready to accumulate.
    assign wr_en     = dly_line[PIPE_DLY-1];
    assign ofm_valid = busy && (out_cnt != '0) && ofm_ready;
    assign rd_en     = {ofm_valid, dly_line[PIPE_DLY-2][KERNEL_SIZE-1:1]};
    assign set_ifm   = xfer;
    assign set_reg   = busy;
    assign out_wr    = wr_en[KERNEL_SIZE-1];

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (state == S_CLEAR) begin
            out_cnt <= '0;
        end else if (out_wr && !ofm_valid) begin
            if (out_cnt != OUT_MAX) out_cnt <= out_cnt + 1'b1;
        end else if (!out_wr && ofm_valid) begin
            out_cnt <= out_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_line_ctrl.sv
// Randomised and directed bench for conv_line_ctrl on a 5x5 map with a 3x3 kernel.
// An event-schedule model predicts every output on every cycle.
module tb_conv_line_ctrl;

    localparam int KS = 3;
    localparam int IW = 5;
    localparam int IH = 5;
    localparam int PD = 3;
    localparam int GC = 2;
    localparam int FS = 10;

    localparam int PH_IDLE = 0, PH_CLR = 1, PH_WGT = 2, PH_FEED = 3, PH_GAP = 4, PH_DRAIN = 5, PH_DONE = 6;

    logic          clk2 = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ifm_valid = 1'b0;
    logic          ofm_ready = 1'b0;
    logic          ifm_ready, set_wgt, set_ifm, set_reg, rd_clr, wr_clr, ofm_valid, busy, done;
    logic [KS-1:0] wr_en, rd_en;
    logic [14:0]   act_vec, exp_vec;

    conv_line_ctrl #(
        .KERNEL_SIZE(KS), .IFM_W(IW), .IFM_H(IH), .PIPE_DLY(PD),
        .GAP_CYC(GC), .FIFO_SIZE(FS), .CNT_WIDTH(8)
    ) dut (
        .clk2(clk2), .rst_n(rst_n), .start(start), .ifm_valid(ifm_valid),
        .ifm_ready(ifm_ready), .ofm_ready(ofm_ready), .set_wgt(set_wgt),
        .set_ifm(set_ifm), .set_reg(set_reg), .wr_en(wr_en), .rd_en(rd_en),
        .rd_clr(rd_clr), .wr_clr(wr_clr), .ofm_valid(ofm_valid), .busy(busy), .done(done)
    );

    always #5 clk2 = ~clk2;

    assign act_vec = {ifm_ready, set_wgt, set_ifm, set_reg, wr_en, rd_en, rd_clr, wr_clr, ofm_valid, busy, done};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model state: phase, pixel index, and absolute-cycle schedules of FIFO strobes.
    int            mc = 0;
    int            m_ph, m_pix, m_gap, m_out, m_last;
    bit [KS-1:0]   ev_wr [int];
    bit [KS-1:0]   ev_rd [int];
    logic [KS-1:0] e_wr, e_rd;
    logic          e_busy, e_rdy, e_ifm, e_ov;
    int            pr, pc;
    bit [KS-1:0]   tmp;

    int cnt_ifm, cnt_clr, cnt_wgt, cnt_done;
    int cnt_wr [KS];
    int cnt_rd [KS];
    int f_ifm, f_clr, f_wgt, f_done, l_rd2;
    int f_wr [KS];
    int f_rd [KS];

    function automatic void model_reset();
        m_ph   = PH_IDLE;
        m_pix  = 0;
        m_gap  = 0;
        m_out  = 0;
        m_last = -1000;
        ev_wr.delete();
        ev_rd.delete();
    endfunction

    function automatic void clear_counts();
        cnt_ifm = 0; cnt_clr = 0; cnt_wgt = 0; cnt_done = 0;
        f_ifm = -1; f_clr = -1; f_wgt = -1; f_done = -1; l_rd2 = -1;
        for (int k = 0; k < KS; k++) begin
            cnt_wr[k] = 0; cnt_rd[k] = 0; f_wr[k] = -1; f_rd[k] = -1;
        end
    endfunction

    always @(negedge clk2) begin
        if (!rst_n) begin
            model_reset();
            check($sformatf("reset_outputs_c%0d", mc), 32'(act_vec), 32'd0);
        end else begin
            e_busy = (m_ph inside {PH_CLR, PH_WGT, PH_FEED, PH_GAP, PH_DRAIN});
            e_rdy  = (m_ph == PH_FEED);
            e_ifm  = e_rdy && ifm_valid;
            e_wr   = ev_wr.exists(mc) ? ev_wr[mc] : '0;
            e_rd   = ev_rd.exists(mc) ? ev_rd[mc] : '0;
            e_ov   = e_busy && (m_out > 0) && ofm_ready;
            e_rd[KS-1] = e_ov;
            exp_vec = {e_rdy, m_ph == PH_WGT, e_ifm, e_busy, e_wr, e_rd,
                       m_ph == PH_CLR, m_ph == PH_CLR, e_ov, e_busy, m_ph == PH_DONE};
            check($sformatf("cycle_c%0d", mc), 32'(act_vec), 32'(exp_vec));

            if (set_ifm) begin cnt_ifm++; if (f_ifm < 0) f_ifm = mc; end
            if (rd_clr)  begin cnt_clr++; if (f_clr < 0) f_clr = mc; end
            if (set_wgt) begin cnt_wgt++; if (f_wgt < 0) f_wgt = mc; end
            if (done)    begin cnt_done++; if (f_done < 0) f_done = mc; end
            for (int k = 0; k < KS; k++) begin
                if (wr_en[k]) begin cnt_wr[k]++; if (f_wr[k] < 0) f_wr[k] = mc; end
                if (rd_en[k]) begin cnt_rd[k]++; if (f_rd[k] < 0) f_rd[k] = mc; end
            end
            if (rd_en[KS-1]) l_rd2 = mc;

            pr = m_pix / IW;
            pc = m_pix % IW;
            if (e_ifm) begin
                if (pc >= KS - 1) begin
                    for (int k = 0; k < KS; k++) begin
                        if (pr - k >= 0 && pr - k <= IH - KS) begin
                            tmp = ev_wr.exists(mc + PD) ? ev_wr[mc + PD] : '0;
                            tmp[k] = 1'b1;
                            ev_wr[mc + PD] = tmp;
                            if (k > 0) begin
                                tmp = ev_rd.exists(mc + PD - 1) ? ev_rd[mc + PD - 1] : '0;
                                tmp[k-1] = 1'b1;
                                ev_rd[mc + PD - 1] = tmp;
                            end
                        end
                    end
                    m_last = mc;
                end
                m_pix++;
            end
            case (m_ph)
                PH_IDLE:  if (start) m_ph = PH_CLR;
                PH_CLR:   m_ph = PH_WGT;
                PH_WGT:   begin m_ph = PH_FEED; m_pix = 0; end
                PH_FEED:  if (e_ifm && pc == IW - 1) begin
                              if (pr == IH - 1) m_ph = PH_DRAIN;
                              else if (GC > 0) begin m_ph = PH_GAP; m_gap = GC; end
                          end
                PH_GAP:   begin m_gap--; if (m_gap == 0) m_ph = PH_FEED; end
                PH_DRAIN: if (mc > m_last + PD && m_out == 0) m_ph = PH_DONE;
                default:  m_ph = PH_IDLE;
            endcase
            m_out = m_out + int'(e_wr[KS-1]) - int'(e_ov);
            if (m_out > FS) m_out = FS;
            ev_wr.delete(mc);
            ev_rd.delete(mc);
        end
        mc++;
    end

    task automatic pulse_start();
        @(posedge clk2); #1 start = 1'b1;
        @(posedge clk2); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && cnt_done == 0; i++) begin
            @(posedge clk2); #1;
        end
        repeat (3) @(posedge clk2);
        #1;
        check({tag, "_done_pulses"}, 32'(cnt_done), 32'd1);
    endtask

    task automatic wait_pixels(input int n);
        for (int i = 0; i < 300 && cnt_ifm < n; i++) begin
            @(posedge clk2); #1;
        end
    endtask

    task automatic check_totals(input string tag);
        check({tag, "_set_ifm"}, 32'(cnt_ifm), 32'd25);
        check({tag, "_clr"}, 32'(cnt_clr), 32'd1);
        check({tag, "_wgt"}, 32'(cnt_wgt), 32'd1);
        for (int k = 0; k < KS; k++) begin
            check($sformatf("%s_wr%0d", tag, k), 32'(cnt_wr[k]), 32'd9);
            check($sformatf("%s_rd%0d", tag, k), 32'(cnt_rd[k]), 32'd9);
        end
    endtask

    initial begin
        #1;
        check("reset_state", 32'(act_vec), 32'd0);
        repeat (3) @(posedge clk2);
        #1 rst_n = 1'b1;
        ifm_valid = 1'b1;
        ofm_ready = 1'b1;

        // Clean map: literal timing of the first strobes relative to the first pixel.
        clear_counts();
        pulse_start();
        wait_done("clean", 300);
        check_totals("clean");
        check("clean_wgt_after_clr", 32'(f_wgt - f_clr), 32'd1);
        check("clean_ifm_after_wgt", 32'(f_ifm - f_wgt), 32'd1);
        check("clean_first_wr0", 32'(f_wr[0] - f_ifm), 32'd5);
        check("clean_first_rd0", 32'(f_rd[0] - f_ifm), 32'd11);
        check("clean_first_rd1", 32'(f_rd[1] - f_ifm), 32'd18);
        check("clean_first_wr2", 32'(f_wr[2] - f_ifm), 32'd19);

        // Four-cycle stall after the second pixel of row 1.
        clear_counts();
        pulse_start();
        wait_pixels(7);
        ifm_valid = 1'b0;
        repeat (4) @(posedge clk2);
        #1 ifm_valid = 1'b1;
        wait_done("stall", 300);
        check_totals("stall");
        check("stall_first_wr0", 32'(f_wr[0] - f_ifm), 32'd5);
        check("stall_first_rd0", 32'(f_rd[0] - f_ifm), 32'd15);
        check("stall_first_rd1", 32'(f_rd[1] - f_ifm), 32'd22);
        check("stall_first_wr2", 32'(f_wr[2] - f_ifm), 32'd23);

        // Output backpressure: everything parks in the output FIFO until ofm_ready rises.
        clear_counts();
        ofm_ready = 1'b0;
        pulse_start();
        wait_pixels(25);
        repeat (12) @(posedge clk2);
        #1;
        check("bp_still_busy", 32'(busy), 32'd1);
        check("bp_not_ready", 32'(ifm_ready), 32'd0);
        check("bp_no_reads", 32'(cnt_rd[KS-1]), 32'd0);
        check("bp_occupancy", 32'(m_out), 32'd9);
        ofm_ready = 1'b1;
        wait_done("bp", 300);
        check_totals("bp");
        check("bp_read_burst", 32'(l_rd2 - f_rd[KS-1]), 32'd8);
        check("bp_done_after_last_read", 32'(f_done - l_rd2), 32'd2);

        // Start while busy is ignored.
        clear_counts();
        pulse_start();
        repeat (10) @(posedge clk2);
        #1 start = 1'b1;
        @(posedge clk2); #1 start = 1'b0;
        wait_done("busy_start", 300);
        check_totals("busy_start");

        // Reset in the middle of row 3, then a full replay.
        clear_counts();
        pulse_start();
        wait_pixels(16);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs", 32'(act_vec), 32'd0);
        repeat (3) @(posedge clk2);
        #1 rst_n = 1'b1;
        clear_counts();
        pulse_start();
        wait_done("replay", 300);
        check_totals("replay");

        // Random valid/ready/start traffic; the per-cycle model does the checking.
        clear_counts();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk2);
            #1;
            ifm_valid = ($urandom_range(0, 9) < 7);
            ofm_ready = ($urandom_range(0, 9) < 6);
            start     = ($urandom_range(0, 19) == 0);
        end
        start = 1'b0;
        ifm_valid = 1'b1;
        ofm_ready = 1'b1;
        repeat (200) @(posedge clk2);
        #1;
        check("rand_maps_completed", 32'(cnt_done > 0), 32'd1);
        check("rand_idle_at_end", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
